// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with a registered four-mode RGB test pattern.
// Define VGA_BORDER_EN to force a white one-pixel border around the active area.
module vga_timing_gen #(
    parameter int unsigned H_DISPLAY    = 640,
    parameter int unsigned H_FRONT      = 16,
    parameter int unsigned H_SYNC       = 96,
    parameter int unsigned H_BACK       = 48,
    parameter int unsigned V_DISPLAY    = 480,
    parameter int unsigned V_FRONT      = 10,
    parameter int unsigned V_SYNC       = 2,
    parameter int unsigned V_BACK       = 33,
    parameter bit          HS_POL       = 1'b0,
    parameter bit          VS_POL       = 1'b0,
    parameter int unsigned COLOR_W      = 4,
    parameter int unsigned CYCLE_FRAMES = 60,
    parameter int unsigned CHECK_LOG2   = 5,
    parameter int unsigned GRAD_SHIFT   = 4,
    localparam int unsigned H_TOTAL     = H_DISPLAY + H_FRONT + H_SYNC + H_BACK,
    localparam int unsigned V_TOTAL     = V_DISPLAY + V_FRONT + V_SYNC + V_BACK,
    localparam int unsigned HW          = $clog2(H_TOTAL),
    localparam int unsigned VW          = $clog2(V_TOTAL)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [1:0]         mode,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic [HW-1:0]      x,
    output logic [VW-1:0]      y,
    output logic               frame_start,
    output logic [COLOR_W-1:0] red,
    output logic [COLOR_W-1:0] green,
    output logic [COLOR_W-1:0] blue
);

    localparam int unsigned HS_START = H_DISPLAY + H_FRONT;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_DISPLAY + V_FRONT;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam int unsigned BAR_W    = H_DISPLAY / 8;
    localparam int unsigned FW       = (CYCLE_FRAMES > 1) ? $clog2(CYCLE_FRAMES) : 1;
    localparam logic [COLOR_W-1:0] FULL = {COLOR_W{1'b1}};

    typedef enum logic [1:0] {
        ColR = 2'd0,
        ColG = 2'd1,
        ColB = 2'd2
    } colour_e;

    logic [HW-1:0]      h_cnt_q, h_cnt_d;
    logic [VW-1:0]      v_cnt_q, v_cnt_d;
    logic [1:0]         mode_q, mode_d;
    logic [FW-1:0]      frame_cnt_q, frame_cnt_d;
    colour_e            colour_q, colour_d;

    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               video_on_q, video_on_d;
    logic               frame_start_q, frame_start_d;
    logic [HW-1:0]      x_q, x_d;
    logic [VW-1:0]      y_q, y_d;
    logic [COLOR_W-1:0] red_q, red_d;
    logic [COLOR_W-1:0] green_q, green_d;
    logic [COLOR_W-1:0] blue_q, blue_d;

    logic [31:0]        h_val, v_val;
    logic               h_last, v_last, frame_first;
    logic [3:0]         bar_k;
    logic               check_on;
    logic [COLOR_W-1:0] pat_r, pat_g, pat_b;

    // Counters, frame pacing and per-frame mode latch.
    always_comb begin
        h_val       = 32'(h_cnt_q);
        v_val       = 32'(v_cnt_q);
        h_last      = (h_val == H_TOTAL - 1);
        v_last      = (v_val == V_TOTAL - 1);
        frame_first = (h_cnt_q == '0) && (v_cnt_q == '0);

        h_cnt_d = h_last ? '0 : h_cnt_q + HW'(1);
        v_cnt_d = v_cnt_q;
        if (h_last) begin
            v_cnt_d = v_last ? '0 : v_cnt_q + VW'(1);
        end

        // The (0,0) pixel already uses the incoming mode, so the whole frame is consistent.
        mode_d = frame_first ? mode : mode_q;

        // Stepping on the last pixel makes the new value govern the frame starting at (0,0).
        frame_cnt_d = frame_cnt_q;
        colour_d    = colour_q;
        if (h_last && v_last) begin
            if (32'(frame_cnt_q) >= CYCLE_FRAMES - 1) begin
                frame_cnt_d = '0;
                case (colour_q)
                    ColR:    colour_d = ColG;
                    ColG:    colour_d = ColB;
                    default: colour_d = ColR;
                endcase
            end else begin
                frame_cnt_d = frame_cnt_q + FW'(1);
            end
        end
    end

    // Pattern generator, evaluated on the current counter state.
    always_comb begin
        bar_k = '0;
        for (int unsigned i = 1; i <= 8; i++) begin
            if (h_val >= i * BAR_W) begin
                bar_k = bar_k + 4'd1;
            end
        end
        check_on = 1'(h_cnt_q >> CHECK_LOG2) ^ 1'(v_cnt_q >> CHECK_LOG2);

        pat_r = '0;
        pat_g = '0;
        pat_b = '0;
        case (mode_d)
            2'd0: begin
                pat_r = (colour_q == ColR) ? FULL : '0;
                pat_g = (colour_q == ColG) ? FULL : '0;
                pat_b = (colour_q == ColB) ? FULL : '0;
            end
            2'd1: begin
                // Bar order 111,110,011,010,101,100,001,000 is (R,G,B) = ~(k[1],k[2],k[0]).
                if (!bar_k[3]) begin
                    pat_r = {COLOR_W{~bar_k[1]}};
                    pat_g = {COLOR_W{~bar_k[2]}};
                    pat_b = {COLOR_W{~bar_k[0]}};
                end
            end
            2'd2: begin
                if (check_on) begin
                    pat_r = FULL;
                    pat_g = FULL;
                    pat_b = FULL;
                end
            end
            default: begin
                pat_r = COLOR_W'(h_cnt_q >> GRAD_SHIFT);
                pat_g = COLOR_W'(v_cnt_q >> GRAD_SHIFT);
            end
        endcase
    end

    // Output stage: everything below is registered together so syncs and colour stay aligned.
    always_comb begin
        hsync_d       = ((h_val >= HS_START) && (h_val < HS_END)) ? HS_POL : ~HS_POL;
        vsync_d       = ((v_val >= VS_START) && (v_val < VS_END)) ? VS_POL : ~VS_POL;
        video_on_d    = (h_val < H_DISPLAY) && (v_val < V_DISPLAY);
        frame_start_d = frame_first;
        x_d           = h_cnt_q;
        y_d           = v_cnt_q;

        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
        if (video_on_d) begin
            red_d   = pat_r;
            green_d = pat_g;
            blue_d  = pat_b;
`ifdef VGA_BORDER_EN
            if ((h_val == 0) || (h_val == H_DISPLAY - 1) ||
                (v_val == 0) || (v_val == V_DISPLAY - 1)) begin
                red_d   = FULL;
                green_d = FULL;
                blue_d  = FULL;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            mode_q        <= '0;
            frame_cnt_q   <= '0;
            colour_q      <= ColR;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            video_on_q    <= 1'b0;
            frame_start_q <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            red_q         <= '0;
            green_q       <= '0;
            blue_q        <= '0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            mode_q        <= mode_d;
            frame_cnt_q   <= frame_cnt_d;
            colour_q      <= colour_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            frame_start_q <= frame_start_d;
            x_q           <= x_d;
            y_q           <= y_d;
            red_q         <= red_d;
            green_q       <= green_d;
            blue_q        <= blue_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign frame_start = frame_start_q;
    assign x           = x_q;
    assign y           = y_q;
    assign red         = red_q;
    assign green       = green_q;
    assign blue        = blue_q;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised successor to the fixed 640x480 VGA controller: generates horizontal/vertical counters, sync pulses and active-video flags for any timing set, with configurable sync polarity. It drives a registered RGB pattern generator with four runtime-selectable test patterns. Syncs and colour are pipeline-aligned. It sits between the pixel-clock domain and the VGA DAC pins on the board top level.

## Interface
- H_DISPLAY, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, active lines
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BACK, 33, vertical back porch (lines)
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level
- COLOR_W, 4, bits per colour channel
- CYCLE_FRAMES, 60, frames per step in solid-cycle mode (>=1)
- CHECK_LOG2, 5, checker square size = 2^CHECK_LOG2 pixels
- GRAD_SHIFT, 4, LSB of x/y used for the gradient
- Derived: H_TOTAL = sum of H_*; V_TOTAL = sum of V_*; HW = $clog2(H_TOTAL); VW = $clog2(V_TOTAL)

Ports:
- clk  in  1  pixel clock
- reset_n  in  1  asynchronous active-low reset
- mode  in  2  pattern select, sampled once per frame
- hsync  out  1  horizontal sync, HS_POL active
- vsync  out  1  vertical sync, VS_POL active
- video_on  out  1  active-video flag
- x  out  HW  pixel column of the current output pixel
- y  out  VW  line of the current output pixel
- frame_start  out  1  one-cycle pulse on pixel (0,0)
- red, green, blue  out  COLOR_W each  pixel colour

## Operation
- Internal h_cnt counts 0..H_TOTAL-1 and wraps. v_cnt increments when h_cnt wraps, and v_cnt counts 0..V_TOTAL-1 then wraps.
- Sync is active while H_DISPLAY+H_FRONT <= h_cnt < H_DISPLAY+H_FRONT+H_SYNC. The vertical window is analogous on v_cnt.
- video_on = (h_cnt < H_DISPLAY) && (v_cnt < V_DISPLAY).
- mode_q loads from mode on the cycle the counters are at (0,0). A mid-frame mode change takes effect only at the next frame.
- Frame counter (0..CYCLE_FRAMES-1) advances at each (0,0). When it wraps, colour state steps R→G→B→R. The colour state is 2 bits; the value 3 is never reached.
- Patterns, with full = all-ones COLOR_W:
  - mode 0, solid: the single channel selected by the colour state = full; the others = 0.
  - mode 1, bars: bar width BW = H_DISPLAY/8 (integer). Bar k = h_cnt/BW, computed by comparison chain or counter, no runtime divider. Bar (R,G,B) order for k = 0..7: 111, 110, 011, 010, 101, 100, 001, 000. Pixels with h_cnt >= 8*BW are black.
  - mode 2, checker: all channels full when h_cnt[CHECK_LOG2] ^ v_cnt[CHECK_LOG2] = 1, else 0.
  - mode 3, gradient: red = h_cnt[GRAD_SHIFT+COLOR_W-1:GRAD_SHIFT], green = v_cnt[same slice], blue = 0.
- RGB is forced to 0 whenever the registered video_on is 0.

## Timing
- All outputs are registered. Values for counter state (h,v) at cycle N appear on outputs at cycle N+1. hsync, vsync, video_on, x, y, frame_start and rgb are mutually aligned, with zero relative skew.
- frame_start is high for exactly one cycle per frame, coincident with x=0, y=0, video_on=1.
- Reset (asynchronous assert, synchronous-safe release):
  - counters, frame counter, colour state (R), mode_q and x/y go to 0;
  - hsync = ~HS_POL, vsync = ~VS_POL;
  - video_on, frame_start and rgb go to 0.
- The first clock after release presents counter state (0,0) on the following edge. A reset mid-frame restarts at (0,0) with no partial-sync glitch beyond the reset values.
- Period is H_TOTAL*V_TOTAL clocks; with the defaults this is 420000.

## Configuration
- VGA_BORDER_EN defined: during active video, pixels with h_cnt = 0, h_cnt = H_DISPLAY-1, v_cnt = 0 or v_cnt = V_DISPLAY-1 are forced to white (all channels full), overriding every mode. This is for monitor alignment checks.
- Undefined: no border logic; the pattern covers the full active area.

## Test plan
- Reset, then run 2 frames with defaults: hsync is low for 96 clocks starting 656 clocks after each line start, and vsync is low for 2 lines (1600 clocks) starting at line 490. The frame_start interval is 420000 clocks.
- Set HS_POL=1, VS_POL=1: the syncs are the inverse of the first case. During reset, hsync=0 and vsync=0.
- mode=1: on line 10, rgb = FFF for x 0..79, FF0 for x 80..159, …, and 000 for x 560..639. rgb = 0 at x 640..799.
- mode=2, then change mode to 3 mid-frame: the checker pattern persists until the next frame_start. The next frame shows red=x[7:4] and green=y[7:4], e.g. (x=0x35, y=0x62) gives red=3, green=6.
- CYCLE_FRAMES=2, mode=0: over frames 0-1 the screen is red, over frames 2-3 green, over frames 4-5 blue, and frame 6 is red again.
- Assert reset_n mid-line at h=300: outputs go to their reset values immediately. After release, the next frame_start arrives 1 cycle later and full-period timing resumes. With VGA_BORDER_EN defined, the pixel at (639,479) = FFF in all modes.
